instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream fetch stage for the single-cycle MIPS datapath. Takes the datapath's pc, reads the
//  instruction word from a variable-latency instruction memory over a req/ack handshake, and
//  presents it on instr. Drives the datapath's enable so pc advances only once per fetched word.
//  Holds a one-entry tag buffer so re-fetching the same pc (e.g. branch-to-self) skips memory.
// PARAMETERS
//  TIMEOUT   16            max FETCH cycles without imem_ack before entering ERROR (>=1)
//  NOP_WORD  32'h00000000  value of instr after reset
// PORTS
//  clk         in   1   single clock; all state updates on posedge clk
//  reset       in   1   synchronous, active-high reset
//  pc          in   32  current pc from datapath (changes only the cycle after enable=1)
//  instr       out  32  fetched instruction word to datapath/control decoder
//  enable      out  1   datapath commit strobe; 1 for exactly one cycle per instruction
//  fetch_err   out  1   sticky error: misaligned pc or memory timeout
//  imem_req    out  1   read request to instruction memory
//  imem_addr   out  32  read address; equals captured pc, stable while imem_req=1
//  imem_ack    in   1   memory response valid; sampled only while imem_req=1
//  imem_rdata  in   32  instruction word, valid when imem_ack=1
// BEHAVIOUR
//  Reset (reset=1 at posedge): state=IDLE, instr=NOP_WORD, enable=0, fetch_err=0, imem_req=0,
//   imem_addr=0, tag_valid=0, tag=0, timeout count=0. Reset wins over every other event.
//  All outputs are registered (Moore); enable=1 iff state==READY; imem_req=1 iff state==FETCH.
//  States:
//   IDLE : pc[1:0]!=0 -> ERROR. Else tag_valid && tag==pc -> READY (hit, no memory access).
//          Else -> FETCH; imem_addr<=pc, count<=0. Exactly one cycle.
//   FETCH: imem_ack=1 -> instr<=imem_rdata, tag<=imem_addr, tag_valid<=1, -> READY.
//          Else count<=count+1; count==TIMEOUT-1 -> ERROR, tag_valid<=0.
//          Ack in the first FETCH cycle is legal (zero-wait memory).
//   READY: enable=1 for this single cycle; -> IDLE unconditionally.
//   ERROR: fetch_err=1, enable=0, imem_req=0; sticky until reset.
//  Latency: miss = 1 (IDLE) + N (FETCH, N>=1 incl. ack cycle) + 1 (READY) cycles per instruction;
//   hit = 2 cycles (IDLE, READY).
//  instr changes only on ack capture in FETCH; stable in IDLE/READY/ERROR (hit keeps old word).
//  imem_ack with imem_req=0 is ignored (no capture, no state change).
//  imem_req drops the cycle after ack (READY); no back-to-back requests without an IDLE cycle.
//  count is $clog2(TIMEOUT+1) bits, saturates, never wraps.
//  tag compares all 32 pc bits; tag_valid cleared by reset or timeout only.
//  Reset mid-FETCH: imem_req=0 at next edge; a late ack is then ignored.
// TESTING
//  1 reset, pc=0x00400000, ack after 3 FETCH cycles, rdata=0x20080005 -> imem_req high 3 cycles,
//    imem_addr=0x00400000, enable one-cycle pulse, instr=0x20080005, fetch_err=0.
//  2 zero-wait memory (ack same cycle as req), pc stepping +4 on each enable -> enable pulses
//    every 3 cycles, imem_addr=0x00400000,0x00400004,0x00400008 in order.
//  3 after fetch of 0x00400010 (rdata=0x1000FFFF), pc held at 0x00400010 -> IDLE->READY,
//    imem_req stays 0, enable every 2 cycles, instr stays 0x1000FFFF.
//  4 TIMEOUT=4, no ack -> imem_req high exactly 4 cycles, then fetch_err=1, enable=0 forever;
//    later ack=1 changes nothing until reset.
//  5 pc=0x00400002 after reset -> ERROR one cycle after IDLE, imem_req never asserted, instr=NOP_WORD.
//  6 reset asserted in 2nd FETCH cycle, ack next cycle -> imem_req=0, instr=NOP_WORD,
//    tag_valid=0; next pc re-fetched from memory (no false hit).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage in front of the single-cycle MIPS datapath. It captures the
// datapath pc, reads the instruction word from a variable-latency instruction
// memory over a req/ack handshake, and presents the word on instr. It also
// drives a one-cycle enable per instruction so the datapath commits, and pc
// advances, exactly once per fetched word. A one-entry tag buffer remembers
// the last fetched address, so fetching the same pc again (for example a
// branch-to-self) skips the memory access.
//
// Ports
//   clk         in   1   single clock, all state updates on posedge
//   reset       in   1   synchronous, active-high reset
//   pc          in   32  current pc from the datapath
//   instr       out  32  fetched instruction word
//   enable      out  1   datapath commit strobe, one cycle per instruction
//   fetch_err   out  1   sticky error: misaligned pc or memory timeout
//   imem_req    out  1   read request to instruction memory
//   imem_addr   out  32  read address, stable while imem_req=1
//   imem_ack    in   1   read response valid, sampled only while imem_req=1
//   imem_rdata  in   32  instruction word, valid with imem_ack
//
// Parameters
//   TIMEOUT     maximum FETCH cycles without ack before ERROR (>=1)
//   NOP_WORD    value of instr after reset
//
// State table
//   state | meaning
//   IDLE  | check pc: misaligned -> ERROR, tag hit -> READY, miss -> FETCH
//   FETCH | imem_req high, wait for ack or timeout
//   READY | enable high for one cycle, instr valid
//   ERROR | fetch_err high, sticky until reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        enable,
  output logic        fetch_err,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   tag_q, tag_d;
  logic          tag_valid_q, tag_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          enable_q, req_q, err_q;

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    count_d     = count_q;

    unique case (state_q)
      IDLE: begin
        if (pc[1:0] != 2'b00) begin
          state_d = ERROR;
        end else if (tag_valid_q && (tag_q == pc)) begin
          // Hit: instr already holds the word for this pc
          state_d = READY;
        end else begin
          state_d = FETCH;
          addr_d  = pc;
          count_d = '0;
        end
      end

      FETCH: begin
        if (imem_ack) begin
          instr_d     = imem_rdata;
          tag_d       = addr_q;
          tag_valid_d = 1'b1;
          state_d     = READY;
        end else begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
          end
          if (count_q == CNT_LAST) begin
            // The buffered tag can no longer be trusted after a failed read
            tag_valid_d = 1'b0;
            state_d     = ERROR;
          end
        end
      end

      READY: begin
        state_d = IDLE;
      end

      ERROR: begin
        state_d = ERROR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_q     <= NOP_WORD;
      addr_q      <= 32'h0000_0000;
      tag_q       <= 32'h0000_0000;
      tag_valid_q <= 1'b0;
      count_q     <= '0;
      enable_q    <= 1'b0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      count_q     <= count_d;
      enable_q    <= (state_d == READY);
      req_q       <= (state_d == FETCH);
      err_q       <= (state_d == ERROR);
    end
  end

  assign instr     = instr_q;
  assign enable    = enable_q;
  assign fetch_err = err_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;

endmodule
